// File: rtl/part2_fsm.sv
// part2_fsm: Moore run detector on serial input w.
// z is set after four or more consecutive equal samples (0000 or 1111).
// The current state code is exported on state for display/debug.
module part2_fsm (
  input  logic       clock,
  input  logic       reset,
  input  logic       w,
  output logic [3:0] state,
  output logic       z
);

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_A = 4'b0000,  // idle / reset
    ST_B = 4'b0001,  // one 0 seen
    ST_C = 4'b0010,  // two 0s seen
    ST_D = 4'b0011,  // three 0s seen
    ST_E = 4'b0100,  // four or more 0s seen
    ST_F = 4'b0101,  // one 1 seen
    ST_G = 4'b0110,  // two 1s seen
    ST_H = 4'b0111,  // three 1s seen
    ST_I = 4'b1000   // four or more 1s seen
  } state_t;

  state_t cur;

  // Next-state value for the current sample; illegal codes fall back to A.
  function automatic state_t next_of(input state_t s, input logic din);
    state_t n;
    n = ST_A;
    case (s)
      ST_A, ST_B, ST_C, ST_D, ST_E, ST_F, ST_G, ST_H, ST_I: begin
        if (din) begin
          case (s)
            ST_F:    n = ST_G;
            ST_G:    n = ST_H;
            ST_H:    n = ST_I;
            ST_I:    n = ST_I;
            default: n = ST_F;
          endcase
        end else begin
          case (s)
            ST_B:    n = ST_C;
            ST_C:    n = ST_D;
            ST_D:    n = ST_E;
            ST_E:    n = ST_E;
            default: n = ST_B;
          endcase
        end
      end
      default: n = ST_A;
    endcase
    return n;
  endfunction

  // Moore output decode: flag only in the two saturated run states.
  function automatic logic run_flag(input state_t s);
    return (s == ST_E) || (s == ST_I);
  endfunction

  // State register with registered z decoded from the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur <= ST_A;
      z   <= 1'b0;
    end else begin
      cur <= next_of(cur, w);
      z   <= run_flag(next_of(cur, w));
    end
  end

  assign state = STATE_W'(cur);

endmodule

// File: tb/tb_part2_fsm.sv
// Directed self-checking bench for part2_fsm.
module tb_part2_fsm;

  logic       clock = 1'b0;
  logic       reset;
  logic       w;
  logic [3:0] state;
  logic       z;

  int tests = 0;
  int fails = 0;

  // 10-unit clock, rising edges at 5, 15, 25, ...
  always #5 clock = ~clock;

  part2_fsm dut (
    .clock (clock),
    .reset (reset),
    .w     (w),
    .state (state),
    .z     (z)
  );

  task automatic check(input string tag, input logic [3:0] es, input logic ez);
    tests++;
    assert (state === es) else begin
      fails++;
      $error("FAIL %s state=%b expected %b", tag, state, es);
    end
    tests++;
    assert (z === ez) else begin
      fails++;
      $error("FAIL %s z=%b expected %b", tag, z, ez);
    end
  endtask

  // Drive one sample and sample outputs 1 unit after the rising edge.
  task automatic step(input logic v);
    w = v;
    @(posedge clock);
    #1;
  endtask

  // Synchronous-looking reset pulse placed between edges.
  task automatic do_reset;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Reference: expected state from current run polarity and length.
  function automatic logic [3:0] exp_state(input logic val, input int len);
    int k;
    k = (len > 4) ? 4 : len;
    if (len == 0) return 4'b0000;
    if (val) return 4'(4 + k);
    return 4'(k);
  endfunction

  initial begin
    logic [3:0] es;
    logic       ez;
    logic       rv;
    int         rl;

    reset = 1'b1;
    w     = 1'b0;
    #12;
    check("reset_hold", 4'b0000, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // Four 1s then a fifth
    step(1'b1); check("ones1", 4'b0101, 1'b0);
    step(1'b1); check("ones2", 4'b0110, 1'b0);
    step(1'b1); check("ones3", 4'b0111, 1'b0);
    step(1'b1); check("ones4", 4'b1000, 1'b1);
    step(1'b1); check("ones5", 4'b1000, 1'b1);

    // Async reset mid-cycle while in I
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 4'b0000, 1'b0);
    @(posedge clock);
    #1;
    check("reset_over_edge", 4'b0000, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    step(1'b0); check("post_reset_w0", 4'b0001, 1'b0);

    // Four 0s from A, then hold
    do_reset();
    step(1'b0); check("zeros1", 4'b0001, 1'b0);
    step(1'b0); check("zeros2", 4'b0010, 1'b0);
    step(1'b0); check("zeros3", 4'b0011, 1'b0);
    step(1'b0); check("zeros4", 4'b0100, 1'b1);
    step(1'b0); check("zeros5", 4'b0100, 1'b1);
    step(1'b0); check("zeros6", 4'b0100, 1'b1);
    step(1'b1); check("zeros_break", 4'b0101, 1'b0);

    // Run-length sweep: n ones then zeros, 11 edges total
    for (int n = 2; n <= 10; n++) begin
      do_reset();
      rv = 1'b0;
      rl = 0;
      for (int k = 1; k <= 11; k++) begin
        logic v;
        v = (k <= n);
        if (rl == 0 || v != rv) begin
          rv = v;
          rl = 1;
        end else begin
          rl++;
        end
        es = exp_state(rv, rl);
        ez = (rl >= 4);
        step(v);
        check($sformatf("sweep_n%0d_k%0d", n, k), es, ez);
      end
    end

    // Alternating input
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) begin
        step(1'b1);
        check($sformatf("alt_%0d", k), 4'b0101, 1'b0);
      end else begin
        step(1'b0);
        check($sformatf("alt_%0d", k), 4'b0001, 1'b0);
      end
    end

    // Broken run, then a full run of 1s
    do_reset();
    step(1'b1); check("brk1", 4'b0101, 1'b0);
    step(1'b1); check("brk2", 4'b0110, 1'b0);
    step(1'b1); check("brk3", 4'b0111, 1'b0);
    step(1'b0); check("brk4", 4'b0001, 1'b0);
    step(1'b1); check("run1", 4'b0101, 1'b0);
    step(1'b1); check("run2", 4'b0110, 1'b0);
    step(1'b1); check("run3", 4'b0111, 1'b0);
    step(1'b1); check("run4", 4'b1000, 1'b1);
    step(1'b0); check("run_drop", 4'b0001, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
